// File: rtl/cic_interp_seq.sv
// Enable sequencer for a CIC interpolator: paces source transfers at one per R clocks,
// issues comb/integrator enables and zero-stuffs the comb input on underrun and flush.
module cic_interp_seq #(
  parameter int unsigned R  = 100,
  parameter int unsigned N  = 1,
  parameter int unsigned PW = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          comb_en,
  output logic          integ_en,
  output logic          zero_stuff,
  output logic          out_valid,
  output logic          busy,
  output logic          underrun,
  output logic [PW-1:0] phase
);

  localparam int unsigned   FW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(R - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          stop_pending_q, stop_pending_d;
  logic          underrun_q, underrun_d;
  logic          out_valid_q, out_valid_d;

  logic          ph_zero;
  logic          ph_last;
  logic [PW-1:0] phase_inc;

  assign ph_zero   = (phase_q == '0);
  assign ph_last   = (phase_q == PH_LAST);
  assign phase_inc = ph_last ? '0 : phase_q + PW'(1);

  // Next-state and enable decode; only zero_stuff looks at an input combinationally.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    flush_cnt_d    = flush_cnt_q;
    stop_pending_d = stop_pending_q;
    underrun_d     = underrun_q;
    src_ready      = 1'b0;
    comb_en        = 1'b0;
    integ_en       = 1'b0;
    zero_stuff     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d        = ST_RUN;
          flush_cnt_d    = '0;
          stop_pending_d = 1'b0;
          underrun_d     = 1'b0;
        end
      end

      ST_RUN: begin
        integ_en = 1'b1;
        phase_d  = phase_inc;
        if (ph_zero) begin
          src_ready  = 1'b1;
          comb_en    = 1'b1;
          zero_stuff = ~src_valid;
          if (!src_valid) begin
            underrun_d = 1'b1;
          end
        end
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (ph_last && (stop_pending_q || stop)) begin
          state_d        = ST_FLUSH;
          phase_d        = '0;
          flush_cnt_d    = '0;
          stop_pending_d = 1'b0;
        end
      end

      ST_FLUSH: begin
        integ_en = 1'b1;
        phase_d  = phase_inc;
        if (ph_zero) begin
          comb_en    = 1'b1;
          zero_stuff = 1'b1;
        end
        if (ph_last) begin
          if (flush_cnt_q == FL_LAST) begin
            state_d     = ST_IDLE;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + FW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    // Integrator output register lags its enable by one clock.
    out_valid_d = integ_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      flush_cnt_q    <= '0;
      stop_pending_q <= 1'b0;
      underrun_q     <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      flush_cnt_q    <= flush_cnt_d;
      stop_pending_q <= stop_pending_d;
      underrun_q     <= underrun_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign underrun  = underrun_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_cic_interp_seq.sv
// Bench for cic_interp_seq: three configurations (R/N = 4/1, 4/2, 100/1) checked against a
// timeline model (cycles since start, run end, flush length) plus hand-computed expectations.
module tb_cic_interp_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start_v[3];
  logic stop_v[3];
  logic sv_v[3];
  logic ready_v[3], comb_v[3], integ_v[3], zs_v[3], ov_v[3], busy_v[3], unr_v[3];
  logic [1:0] ph0, ph1;
  logic [6:0] ph2;

  cic_interp_seq #(.R(4), .N(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]), .src_valid(sv_v[0]),
    .src_ready(ready_v[0]), .comb_en(comb_v[0]), .integ_en(integ_v[0]),
    .zero_stuff(zs_v[0]), .out_valid(ov_v[0]), .busy(busy_v[0]), .underrun(unr_v[0]),
    .phase(ph0));

  cic_interp_seq #(.R(4), .N(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]), .src_valid(sv_v[1]),
    .src_ready(ready_v[1]), .comb_en(comb_v[1]), .integ_en(integ_v[1]),
    .zero_stuff(zs_v[1]), .out_valid(ov_v[1]), .busy(busy_v[1]), .underrun(unr_v[1]),
    .phase(ph1));

  cic_interp_seq #(.R(100), .N(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .stop(stop_v[2]), .src_valid(sv_v[2]),
    .src_ready(ready_v[2]), .comb_en(comb_v[2]), .integ_en(integ_v[2]),
    .zero_stuff(zs_v[2]), .out_valid(ov_v[2]), .busy(busy_v[2]), .underrun(unr_v[2]),
    .phase(ph2));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst%0d] t=%0t: got %0d, expected %0d", nm, i, $time, act, exp);
    end
  endtask

  function automatic int unsigned rv(input int i);
    return (i == 2) ? 100 : 4;
  endfunction

  function automatic int unsigned nv(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] ph_act(input int i);
    case (i)
      0:       return 32'(ph0);
      1:       return 32'(ph1);
      default: return 32'(ph2);
    endcase
  endfunction

  // Model: t = cycles since the first active cycle; the run ends at m_end (set at stop),
  // followed by N*R flush cycles.
  bit          m_act[3], m_stopped[3], m_unr[3], m_ov[3];
  int unsigned m_t[3], m_end[3];

  function automatic bit m_in_run(input int i);
    return m_act[i] && (!m_stopped[i] || m_t[i] < m_end[i]);
  endfunction

  function automatic bit m_comb(input int i);
    return m_act[i] && (m_t[i] % rv(i) == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] <= 1'b0; m_stopped[i] <= 1'b0; m_unr[i] <= 1'b0; m_ov[i] <= 1'b0;
        m_t[i] <= 0; m_end[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic int unsigned t_n   = m_t[i] + 1;
        automatic int unsigned end_n = m_end[i];
        automatic bit          st_n  = m_stopped[i];
        m_ov[i] <= m_act[i];
        if (!m_act[i]) begin
          if (start_v[i]) begin
            m_act[i] <= 1'b1; m_t[i] <= 0; m_stopped[i] <= 1'b0; m_unr[i] <= 1'b0;
          end
        end else begin
          if (m_in_run(i) && (m_t[i] % rv(i) == 0) && !sv_v[i]) m_unr[i] <= 1'b1;
          if (stop_v[i] && !st_n) begin
            st_n  = 1'b1;
            end_n = (m_t[i] / rv(i) + 1) * rv(i);
          end
          m_t[i] <= t_n; m_stopped[i] <= st_n; m_end[i] <= end_n;
          if (st_n && t_n >= end_n + nv(i) * rv(i)) begin
            m_act[i] <= 1'b0; m_t[i] <= 0;
          end
        end
      end
    end
  end

  // Compare process plus activity counters, on the falling edge.
  int cnt_comb[3], cnt_xfer[3], cnt_zsc[3], cnt_busy[3];
  int cyc = 0, last_comb2 = -1, spacing_bad = 0, max_ph2 = 0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      chk("busy",      i, 32'(busy_v[i]),  32'(m_act[i]));
      chk("integ_en",  i, 32'(integ_v[i]), 32'(m_act[i]));
      chk("comb_en",   i, 32'(comb_v[i]),  32'(m_comb(i)));
      chk("src_ready", i, 32'(ready_v[i]), 32'(m_comb(i) && m_in_run(i)));
      chk("zero_stuff",i, 32'(zs_v[i]),    32'(m_comb(i) && (!m_in_run(i) || !sv_v[i])));
      chk("out_valid", i, 32'(ov_v[i]),    32'(m_ov[i]));
      chk("underrun",  i, 32'(unr_v[i]),   32'(m_unr[i]));
      chk("phase",     i, ph_act(i),       m_act[i] ? m_t[i] % rv(i) : 0);
      if (comb_v[i] === 1'b1) cnt_comb[i]++;
      if (comb_v[i] === 1'b1 && zs_v[i] === 1'b1) cnt_zsc[i]++;
      if (ready_v[i] === 1'b1 && sv_v[i] === 1'b1) cnt_xfer[i]++;
      if (busy_v[i] === 1'b1) cnt_busy[i]++;
    end
    if (comb_v[2] === 1'b1) begin
      if (last_comb2 >= 0 && cyc - last_comb2 != 100) spacing_bad++;
      last_comb2 = cyc;
    end
    if (int'(ph2) > max_ph2) max_ph2 = int'(ph2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while (busy_v[i] === 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", i, 32'(busy_v[i]), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s_comb, s_xfer, s_zsc, s_busy;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; stop_v[i] = 1'b0; sv_v[i] = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 0, 32'(busy_v[0]), 0);
    chk("rst_phase", 2, 32'(ph2), 0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Streaming, underrun and stop on R=4, N=1.
    start_v[0] = 1'b1; sv_v[0] = 1'b1;          // cycle 0
    step(); start_v[0] = 1'b0;                  // cycle 1
    mid();
    chk("c1_comb", 0, 32'(comb_v[0]), 1);
    chk("c1_ready", 0, 32'(ready_v[0]), 1);
    chk("c1_ov", 0, 32'(ov_v[0]), 0);
    step(); mid();                              // cycle 2
    chk("c2_ov", 0, 32'(ov_v[0]), 1);
    chk("c2_phase", 0, 32'(ph0), 1);
    repeat (3) step(); mid();                   // cycle 5
    chk("c5_comb", 0, 32'(comb_v[0]), 1);
    repeat (4) step(); sv_v[0] = 1'b0;          // cycle 9
    mid();
    chk("c9_zs", 0, 32'(zs_v[0]), 1);
    chk("c9_unr", 0, 32'(unr_v[0]), 0);
    step(); sv_v[0] = 1'b1;                     // cycle 10
    mid();
    chk("c10_unr", 0, 32'(unr_v[0]), 1);
    chk("c10_ready", 0, 32'(ready_v[0]), 0);
    repeat (3) step(); mid();                   // cycle 13
    chk("c13_ready", 0, 32'(ready_v[0]), 1);
    chk("c13_zs", 0, 32'(zs_v[0]), 0);
    step(); stop_v[0] = 1'b1;                   // cycle 14, phase 1
    step(); stop_v[0] = 1'b0;                   // cycle 15
    repeat (2) step(); mid();                   // cycle 17, first flush cycle
    chk("f0_comb", 0, 32'(comb_v[0]), 1);
    chk("f0_zs", 0, 32'(zs_v[0]), 1);
    chk("f0_ready", 0, 32'(ready_v[0]), 0);
    repeat (4) step(); mid();                   // cycle 21, idle
    chk("idle_busy", 0, 32'(busy_v[0]), 0);
    chk("idle_ov", 0, 32'(ov_v[0]), 1);
    step(); mid();                              // cycle 22
    chk("idle_ov2", 0, 32'(ov_v[0]), 0);
    chk("idle_unr", 0, 32'(unr_v[0]), 1);
    step(); start_v[0] = 1'b1;
    step(); start_v[0] = 1'b0; stop_v[0] = 1'b1;
    mid();
    chk("restart_unr", 0, 32'(unr_v[0]), 0);
    step(); stop_v[0] = 1'b0;
    wait_idle(0, 50);

    // Start+stop together, then a later stop, on R=4, N=2.
    step();
    start_v[1] = 1'b1; stop_v[1] = 1'b1; sv_v[1] = 1'b1;
    s_comb = cnt_comb[1]; s_xfer = cnt_xfer[1]; s_zsc = cnt_zsc[1]; s_busy = cnt_busy[1];
    step(); start_v[1] = 1'b0; stop_v[1] = 1'b0; // cycle 1
    repeat (9) step(); stop_v[1] = 1'b1;        // cycle 10, phase 1
    step(); stop_v[1] = 1'b0;
    wait_idle(1, 50);
    chk("n2_busy_cycles", 1, cnt_busy[1] - s_busy, 20);
    chk("n2_comb", 1, cnt_comb[1] - s_comb, 5);
    chk("n2_zs_comb", 1, cnt_zsc[1] - s_zsc, 2);
    chk("n2_xfer", 1, cnt_xfer[1] - s_xfer, 3);

    // Asynchronous reset in the middle of a flush.
    step(); start_v[1] = 1'b1;
    step(); start_v[1] = 1'b0; stop_v[1] = 1'b1;
    step(); stop_v[1] = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", 1, 32'(busy_v[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 1, 32'(busy_v[1]), 0);
    chk("arst_integ", 1, 32'(integ_v[1]), 0);
    chk("arst_ov", 1, 32'(ov_v[1]), 0);
    chk("arst_phase", 1, 32'(ph1), 0);
    step(); step(); rst = 1'b0;
    step(); start_v[1] = 1'b1;
    step(); start_v[1] = 1'b0;
    mid();
    chk("rst_restart_ready", 1, 32'(ready_v[1]), 1);
    chk("rst_restart_phase", 1, 32'(ph1), 0);
    step(); stop_v[1] = 1'b1;
    step(); stop_v[1] = 1'b0;
    wait_idle(1, 50);

    // R=100, N=1: ten periods then stop.
    step();
    start_v[2] = 1'b1; sv_v[2] = 1'b1;
    s_comb = cnt_comb[2]; s_xfer = cnt_xfer[2]; s_busy = cnt_busy[2];
    step(); start_v[2] = 1'b0;
    repeat (950) step();
    stop_v[2] = 1'b1;
    step(); stop_v[2] = 1'b0;
    wait_idle(2, 2000);
    chk("r100_comb", 2, cnt_comb[2] - s_comb, 11);
    chk("r100_xfer", 2, cnt_xfer[2] - s_xfer, 10);
    chk("r100_busy_cycles", 2, cnt_busy[2] - s_busy, 1100);
    chk("r100_spacing_bad", 2, spacing_bad, 0);
    chk("r100_max_phase", 2, max_ph2, 99);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
